shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a power of two and at least 4.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; SHALL be at least log2(WIDTH).
REQ-003 Parameter STEP, default 1, maximum bit positions shifted per cycle; SHALL be in the range 1..WIDTH.
REQ-004 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, reset; SHALL be asynchronous and active-low.
REQ-006 Port in_valid, input, 1, request valid.
REQ-007 Port in_ready, output, 1, unit can accept a request.
REQ-008 Port in_data, input, WIDTH, operand.
REQ-009 Port shamt, input, SHAMT_W, unsigned shift amount.
REQ-010 Port mode, input, 2, operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-011 Port out_valid, output, 1, result valid.
REQ-012 Port out_ready, input, 1, consumer accepts the result.
REQ-013 Port out_data, output, WIDTH, result.
REQ-014 Port out_carry, output, 1, last bit shifted or rotated out.
REQ-015 Port out_zero, output, 1, out_data equals 0.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE and out_valid SHALL be 1 only in DONE.
REQ-017 Accept: when in_valid and in_ready are both high at a clock edge, the unit SHALL capture in_data, mode and an effective count eff, then enter SHIFT if eff>0 or DONE if eff=0.
REQ-018 Effective count for SLL, SRL and SRA SHALL be eff = min(shamt, WIDTH).
REQ-019 Effective count for ROR SHALL be eff = shamt mod WIDTH.
REQ-020 In SHIFT, each edge SHALL shift the working register by n = min(STEP, remaining) positions and decrement remaining by n; when remaining reaches 0 the FSM SHALL go to DONE.
REQ-021 The result SHALL be valid k = ceil(eff/STEP) edges after the accept edge; for eff=0 the result SHALL be valid in the cycle immediately after accept.
REQ-022 Per-mode fill: SLL fills with 0 at the LSB; SRL fills with 0 at the MSB; SRA replicates the captured sign bit (bit WIDTH-1); ROR wraps the LSB into the MSB.
REQ-023 out_carry SHALL equal the last bit shifted out over all eff steps (for ROR, the last bit wrapped), and SHALL be 0 when eff=0.
REQ-024 out_zero SHALL equal (out_data == 0) whenever out_valid is high.
REQ-025 In DONE, out_data, out_carry and out_zero SHALL stay stable until out_valid and out_ready are both high at an edge; the FSM SHALL then return to IDLE.
REQ-026 Back-to-back: a new request SHALL NOT be accepted in the same cycle as a DONE handshake; it SHALL be accepted no earlier than the following IDLE cycle.
REQ-027 in_valid, in_data, shamt and mode SHALL be ignored while in SHIFT or DONE; changes on these inputs SHALL NOT affect an in-flight operation.
REQ-028 out_ready SHALL be ignored outside DONE.

Reset
REQ-029 While rst_n is 0, the FSM SHALL be in IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, out_zero=1, and remaining=0, independent of clk.
REQ-030 Assertion of rst_n mid-operation (in SHIFT or DONE) SHALL abort the operation immediately; no result SHALL be presented after the reset is released.
REQ-031 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-032 WIDTH=8, STEP=1, SRA, in_data=0x96, shamt=3 -> out_data=0xF2, out_carry=1, out_zero=0, out_valid rises 3 edges after accept.
REQ-033 WIDTH=8, STEP=2, same stimulus as REQ-032 -> same result, with out_valid rising 2 edges after accept.
REQ-034 SRL, in_data=0xFF, shamt=9 -> eff=8, out_data=0x00, out_zero=1, out_carry=1; SLL, in_data=0x81, shamt=1 -> out_data=0x02, out_carry=1.
REQ-035 ROR, in_data=0x01, shamt=9 -> eff=1, out_data=0x80, out_carry=1; any mode with shamt=0 -> out_data=in_data, out_carry=0, out_valid in the cycle after accept.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and in_data -> outputs stay stable, in_ready stays 0, and no second capture occurs.
REQ-037 Assert rst_n=0 asynchronously during SHIFT -> outputs take their reset values without waiting for a clock edge; after release, no stale out_valid appears.

Source files
------------

// File: rtl/shift_unit.sv
// Multi-cycle barrel-free shifter: SLL/SRL/SRA/ROR, up to STEP positions per cycle,
// with valid/ready handshakes on both sides.
module shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;
  localparam int MW = (SHAMT_W > CW) ? SHAMT_W : CW;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CW-1:0]    rem;
  logic [1:0]       mode_q;

  logic [MW-1:0]    sh_ext;
  logic [CW-1:0]    eff;
  logic [WIDTH-1:0] nxt_work;
  logic             nxt_carry;
  logic [CW-1:0]    nxt_rem;

  always_comb begin
    sh_ext = MW'(shamt);
    if (mode == 2'b11)
      eff = CW'(shamt[LW-1:0]);
    else if (sh_ext >= MW'(WIDTH))
      eff = CW'(WIDTH);
    else
      eff = CW'(sh_ext);
  end

  // Up to STEP single-bit shifts per cycle, stopping early when fewer remain.
  always_comb begin
    nxt_work  = work;
    nxt_carry = carry;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < 32'(rem)) begin
        case (mode_q)
          2'b00: begin
            nxt_carry = nxt_work[WIDTH-1];
            nxt_work  = {nxt_work[WIDTH-2:0], 1'b0};
          end
          2'b01: begin
            nxt_carry = nxt_work[0];
            nxt_work  = {1'b0, nxt_work[WIDTH-1:1]};
          end
          2'b10: begin
            nxt_carry = nxt_work[0];
            nxt_work  = {nxt_work[WIDTH-1], nxt_work[WIDTH-1:1]};
          end
          default: begin
            nxt_carry = nxt_work[0];
            nxt_work  = {nxt_work[0], nxt_work[WIDTH-1:1]};
          end
        endcase
      end
    end
    nxt_rem = (rem > CW'(STEP)) ? rem - CW'(STEP) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_zero  <= 1'b1;
      work      <= '0;
      carry     <= 1'b0;
      rem       <= '0;
      mode_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            mode_q   <= mode;
            carry    <= 1'b0;
            rem      <= eff;
            in_ready <= 1'b0;
            if (eff == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_zero  <= (in_data == '0);
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= nxt_work;
          carry <= nxt_carry;
          rem   <= nxt_rem;
          if (nxt_rem == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_zero  <= (nxt_work == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data  = work;
  assign out_carry = carry;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: two instances (STEP=1 and STEP=2) share stimulus;
// results, latency, backpressure and asynchronous reset are checked.
module tb_shift_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic [4:0] shamt;
  logic [1:0] mode;

  logic       ir1, ov1, oc1, oz1;
  logic [7:0] od1;
  logic       ir2, ov2, oc2, oz2;
  logic [7:0] od2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(8), .SHAMT_W(5), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .shamt(shamt), .mode(mode), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_carry(oc1), .out_zero(oz1)
  );

  shift_unit #(.WIDTH(8), .SHAMT_W(5), .STEP(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .shamt(shamt), .mode(mode), .out_valid(ov2),
    .out_ready(out_ready), .out_data(od2), .out_carry(oc2), .out_zero(oz2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request to both instances, scramble inputs while busy, then handshake.
  task automatic run_op(input string name, input logic [1:0] m, input logic [7:0] d,
                        input logic [4:0] s, input logic [7:0] ed, input logic ec,
                        input int k1, input int k2);
    int c, lat1, lat2;
    @(negedge clk);
    chk({name, " ready1"}, ir1, 1'b1);
    chk({name, " ready2"}, ir2, 1'b1);
    in_valid = 1'b1; mode = m; in_data = d; shamt = s;
    @(posedge clk); #1;
    in_data = ~d; mode = m + 2'd1; shamt = s + 5'd3;
    c = 0; lat1 = -1; lat2 = -1;
    while ((lat1 < 0 || lat2 < 0) && c < 40) begin
      if (lat1 < 0 && ov1) lat1 = c;
      if (lat2 < 0 && ov2) lat2 = c;
      if (lat1 < 0 || lat2 < 0) begin
        @(posedge clk); #1;
        c++;
      end
    end
    in_valid = 1'b0;
    chk({name, " latency1"}, 32'(lat1), 32'(k1));
    chk({name, " latency2"}, 32'(lat2), 32'(k2));
    chk({name, " data1"},  od1, ed);
    chk({name, " carry1"}, oc1, ec);
    chk({name, " zero1"},  oz1, (ed == 8'h00));
    chk({name, " data2"},  od2, ed);
    chk({name, " carry2"}, oc2, ec);
    chk({name, " zero2"},  oz2, (ed == 8'h00));
    chk({name, " busy_ready1"}, ir1, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " post_valid1"}, ov1, 1'b0);
    chk({name, " post_valid2"}, ov2, 1'b0);
    chk({name, " post_ready1"}, ir1, 1'b1);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; mode = 2'b00; in_data = 8'h81; shamt = 5'd1;
    #12;
    chk("rst ready",  ir1, 1'b1);
    chk("rst valid",  ov1, 1'b0);
    chk("rst data",   od1, 8'h00);
    chk("rst carry",  oc1, 1'b0);
    chk("rst zero",   oz1, 1'b1);
    chk("rst accept_blocked", u1.rem, 4'd0);

    // Request is already pending: first edge after release must accept it.
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_edge accept", ir1, 1'b0);
    chk("first_edge valid",  ov1, 1'b0);
    @(posedge clk); #1;
    chk("sll81 valid", ov1, 1'b1);
    chk("sll81 data",  od1, 8'h02);
    chk("sll81 carry", oc1, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("sll81 idle", ir1, 1'b1);

    run_op("sra96_3",  2'b10, 8'h96, 5'd3,  8'hF2, 1'b1, 3, 2);
    run_op("srlff_9",  2'b01, 8'hFF, 5'd9,  8'h00, 1'b1, 8, 4);
    run_op("sll81_1",  2'b00, 8'h81, 5'd1,  8'h02, 1'b1, 1, 1);
    run_op("ror01_9",  2'b11, 8'h01, 5'd9,  8'h80, 1'b1, 1, 1);
    run_op("sll5a_0",  2'b00, 8'h5A, 5'd0,  8'h5A, 1'b0, 0, 0);
    run_op("rorc3_8",  2'b11, 8'hC3, 5'd8,  8'hC3, 1'b0, 0, 0);
    run_op("sll0f_5",  2'b00, 8'h0F, 5'd5,  8'hE0, 1'b1, 5, 3);
    run_op("sra80_20", 2'b10, 8'h80, 5'd20, 8'hFF, 1'b1, 8, 4);
    run_op("ror96_11", 2'b11, 8'h96, 5'd11, 8'hD2, 1'b1, 3, 2);
    run_op("srl96_2",  2'b01, 8'h96, 5'd2,  8'h25, 1'b1, 2, 1);
    run_op("sra00_0",  2'b10, 8'h00, 5'd0,  8'h00, 1'b0, 0, 0);

    // Backpressure: stay in DONE with noisy inputs.
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b00; in_data = 8'h81; shamt = 5'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    while (!ov1 && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    chk("bp reach_done", ov1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data  = 8'(i * 37 + 5);
      mode     = 2'(i);
      shamt    = 5'(i);
      @(posedge clk); #1;
      chk("bp data",  od1, 8'h02);
      chk("bp carry", oc1, 1'b1);
      chk("bp zero",  oz1, 1'b0);
      chk("bp valid", ov1, 1'b1);
      chk("bp ready", ir1, 1'b0);
      chk("bp data2", od2, 8'h02);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release_valid", ov1, 1'b0);
    chk("bp release_ready", ir1, 1'b1);
    @(posedge clk); #1;
    chk("bp no_second_capture", ir1, 1'b1);

    // Asynchronous reset in the middle of an 8-step shift.
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b01; in_data = 8'hFF; shamt = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid busy", ir1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async ready", ir1, 1'b1);
    chk("async valid", ov1, 1'b0);
    chk("async data",  od1, 8'h00);
    chk("async carry", oc1, 1'b0);
    chk("async zero",  oz1, 1'b1);
    chk("async ready2", ir2, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stale valid1", ov1, 1'b0);
      chk("stale valid2", ov2, 1'b0);
    end

    run_op("after_rst", 2'b10, 8'h96, 5'd3, 8'hF2, 1'b1, 3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
